memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 32, the data and address width.
REQ-002 The block SHALL provide the following ports, one per line, as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_en  in  1  instruction accesses data memory.
- Load  in  1  load instruction.
- Store  in  1  store instruction.
- fun3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_to_reg  in  2  writeback select: 00 ALU, 01 load data, 10 pc_plus4, 11 zero.
- alu_result  in  DATA_WIDTH  effective address, or ALU writeback value.
- store_data  in  DATA_WIDTH  rs2 value for stores.
- pc_plus4  in  DATA_WIDTH  link value.
- dmem_rdata  in  DATA_WIDTH  read word from data memory.
- dmem_ack  in  1  memory completes the current request.
- dmem_req  out  1  request valid.
- dmem_we  out  1  write request.
- dmem_addr  out  DATA_WIDTH  word-aligned address.
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data.
- dmem_wmask  out  4  byte-lane write enables.
- DM_valid  out  1  one-cycle completion pulse for the memory operation.
- misalign_err  out  1  one-cycle pulse for a rejected misaligned access.
- rwd_data_out  out  DATA_WIDTH  register-file writeback data.

Function
REQ-003 The state machine SHALL have three states: IDLE, REQ and DONE.
REQ-004 In IDLE with mem_en=1 and (Load or Store)=1, the block SHALL capture address, store_data, fun3 and the access type into registers. Load SHALL take priority if Load and Store are both 1.
REQ-005 Misalignment SHALL be checked at capture: word access with addr[1:0]!=0, or halfword access with addr[0]!=0. A misaligned access SHALL issue no request and SHALL go to DONE with misalign_err=1 and DM_valid=1 for that one cycle. The load data register SHALL be left unchanged.
REQ-006 An aligned accept SHALL go to REQ. In REQ, dmem_req SHALL be 1, and dmem_addr, dmem_we, dmem_wdata and dmem_wmask SHALL come from the captured registers and stay stable until dmem_ack is sampled 1.
REQ-007 REQ SHALL go to DONE on the edge where dmem_ack=1. On that edge, for a load, the block SHALL register the extracted and extended read data.
REQ-008 DONE SHALL last exactly one cycle with DM_valid=1, then go to IDLE. A request present during DONE SHALL NOT be accepted until the following IDLE cycle.
REQ-009 Minimum latency SHALL be: accept edge T, dmem_req high in cycle T+1, and with ack in T+1, DM_valid high in cycle T+2. Each extra wait cycle SHALL add one cycle.
REQ-010 Store lanes SHALL be:
- SB: wmask=0001<<addr[1:0], wdata=byte replicated x4.
- SH: wmask=0011<<{addr[1],1'b0}, wdata=half replicated x2.
- SW: wmask=1111.
- Loads: dmem_we=0 and wmask=0000.
REQ-011 Load extraction SHALL select the lane by captured addr[1:0]. B and H SHALL be sign-extended, BU and HU zero-extended, and W taken unchanged.
REQ-012 rwd_data_out SHALL be combinational from mem_to_reg: alu_result, the load data register, pc_plus4, or 0.
REQ-013 dmem_ack SHALL be ignored in IDLE and DONE. An instruction with mem_en=0 SHALL cause no state change.
REQ-014 Inputs SHALL NOT be re-sampled while in REQ or DONE, so input changes have no effect until IDLE.

Reset
REQ-015 With rst=1 at an edge, the block SHALL enter IDLE from any state, including mid-request, and SHALL set dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wmask=0, DM_valid=0, misalign_err=0 and the load data register to 0.
REQ-016 An ack arriving after a mid-request reset SHALL be ignored.

Verification
REQ-017 SW: addr=0x100, store_data=0xDEADBEEF, ack in the first REQ cycle -> dmem_req for 1 cycle, wmask=1111, wdata=0xDEADBEEF, addr=0x100, DM_valid two cycles after accept.
REQ-018 LB: addr=0x203, rdata=0x80FF_1234, ack after 3 wait cycles -> dmem_req held 4 cycles, addr=0x200, rwd_data_out=0xFFFFFF80 with mem_to_reg=01; LBU on the same data -> 0x00000080.
REQ-019 SH: addr=0x42, store_data=0x0000ABCD -> wmask=1100, wdata=0xABCDABCD; LHU from addr 0x42 with rdata=0xABCD0000 -> 0x0000ABCD.
REQ-020 LW at addr 0x101 -> no dmem_req, misalign_err=1 and DM_valid=1 in the same single cycle, load register unchanged.
REQ-021 rst pulsed during REQ, then ack asserted -> dmem_req=0 after the reset edge, no DM_valid, state IDLE; mem_to_reg=10 with pc_plus4=0x24 -> rwd_data_out=0x24.

Source files
------------

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : memory_stage
//  Description : Pipeline memory stage. Captures one load/store, issues a
//                single data-memory request, waits for ack, extracts and
//                extends load data, and muxes register-file writeback data.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_en,
    input  logic                  Load,
    input  logic                  Store,
    input  logic [2:0]            fun3,
    input  logic [1:0]            mem_to_reg,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] pc_plus4,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_wmask,
    output logic                  DM_valid,
    output logic                  misalign_err,
    output logic [DATA_WIDTH-1:0] rwd_data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [2:0]            r_fun3;
    logic [1:0]            r_lo;
    logic [DATA_WIDTH-1:0] r_load_data;
    logic                  r_req;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_wmask;
    logic                  r_dm_valid;
    logic                  r_misalign;

    logic                  w_accept;
    logic                  w_misalign;
    logic [3:0]            w_store_mask;
    logic [DATA_WIDTH-1:0] w_store_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_ext;

    // fun3[1:0]: 00 byte, 01 half, anything else treated as a full word
    assign w_accept   = mem_en && (Load || Store);
    assign w_misalign = ((fun3[1:0] == 2'b01) && alu_result[0]) ||
                        (fun3[1] && (alu_result[1:0] != 2'b00));

    // Byte-lane enables and lane-replicated write data for the incoming store
    always_comb begin
        w_store_mask  = 4'b1111;
        w_store_wdata = store_data;
        case (fun3[1:0])
            2'b00: begin
                w_store_mask  = 4'b0001 << alu_result[1:0];
                w_store_wdata = {(DATA_WIDTH/8){store_data[7:0]}};
            end
            2'b01: begin
                w_store_mask  = 4'b0011 << {alu_result[1], 1'b0};
                w_store_wdata = {(DATA_WIDTH/16){store_data[15:0]}};
            end
            default: begin
                w_store_mask  = 4'b1111;
                w_store_wdata = store_data;
            end
        endcase
    end

    // Lane selection and sign/zero extension of the returned read word
    always_comb begin
        w_byte     = dmem_rdata[{r_lo, 3'b000} +: 8];
        w_half     = dmem_rdata[{r_lo[1], 4'b0000} +: 16];
        w_load_ext = dmem_rdata;
        case (r_fun3)
            3'b000:  w_load_ext = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b100:  w_load_ext = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_load_ext = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_load_ext = dmem_rdata;
        endcase
    end

    // Access sequencer: capture in IDLE, hold request until ack, one-cycle DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fun3      <= 3'b000;
            r_lo        <= 2'b00;
            r_load_data <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= 4'b0000;
            r_dm_valid  <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_dm_valid <= 1'b0;
                    r_misalign <= 1'b0;
                    if (w_accept) begin
                        r_fun3  <= fun3;
                        r_lo    <= alu_result[1:0];
                        r_addr  <= {alu_result[DATA_WIDTH-1:2], 2'b00};
                        r_we    <= ~Load;
                        r_wmask <= Load ? 4'b0000 : w_store_mask;
                        r_wdata <= w_store_wdata;
                        if (w_misalign) begin
                            // Rejected access completes immediately without a request
                            r_dm_valid <= 1'b1;
                            r_misalign <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_req   <= 1'b1;
                            r_state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        r_req      <= 1'b0;
                        r_dm_valid <= 1'b1;
                        if (!r_we) begin
                            r_load_data <= w_load_ext;
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_dm_valid <= 1'b0;
                    r_misalign <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_req      <= 1'b0;
                    r_dm_valid <= 1'b0;
                    r_misalign <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    // Writeback source selection
    always_comb begin
        rwd_data_out = '0;
        case (mem_to_reg)
            2'b00:   rwd_data_out = alu_result;
            2'b01:   rwd_data_out = r_load_data;
            2'b10:   rwd_data_out = pc_plus4;
            default: rwd_data_out = '0;
        endcase
    end

    assign dmem_req     = r_req;
    assign dmem_we      = r_we;
    assign dmem_addr    = r_addr;
    assign dmem_wdata   = r_wdata;
    assign dmem_wmask   = r_wmask;
    assign DM_valid     = r_dm_valid;
    assign misalign_err = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_stage
//  Description : Randomized scoreboard bench for memory_stage with a
//                behavioural reference model of loads, stores and writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic        Load;
    logic        Store;
    logic [2:0]  fun3;
    logic [1:0]  mem_to_reg;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] pc_plus4;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        DM_valid;
    logic        misalign_err;
    logic [31:0] rwd_data_out;

    memory_stage #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en       (mem_en),
        .Load         (Load),
        .Store        (Store),
        .fun3         (fun3),
        .mem_to_reg   (mem_to_reg),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .pc_plus4     (pc_plus4),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wmask   (dmem_wmask),
        .DM_valid     (DM_valid),
        .misalign_err (misalign_err),
        .rwd_data_out (rwd_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] wdata;
        int          cycles;
    } req_t;

    typedef struct {
        logic        mis;
        logic [31:0] ld;
        int          cyc;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_ld = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: architectural meaning of a load of fun3 from address a
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * (a % 4))) & 32'hFF;
        h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return rd;
        endcase
    endfunction

    // Scrambles inputs that must be ignored while an access is in flight
    task automatic garble();
        mem_en     = 1'($urandom);
        Load       = 1'($urandom);
        Store      = 1'($urandom);
        fun3       = 3'($urandom);
        alu_result = $urandom;
        store_data = $urandom;
    endtask

    // One transaction; entry and exit at #1 after a rising edge with the DUT idle
    task automatic do_txn(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rd, input int waits);
        req_t  r;
        resp_t p;
        int    size;
        logic  mis;
        int    t;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis  = (a % size) != 0;
        t    = cyc + 1;
        if (!mis) begin
            r.addr   = a - (a % 4);
            r.we     = !ld;
            r.mask   = ld ? 4'b0000 : (size == 1) ? 4'(1 << (a % 4)) :
                       (size == 2) ? 4'(3 << (a % 4)) : 4'b1111;
            r.wdata  = (size == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
                       (size == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
            r.cycles = waits + 1;
            req_q.push_back(r);
            if (ld) model_ld = ref_load(f3, a, rd);
        end
        p.mis = mis;
        p.ld  = model_ld;
        p.cyc = mis ? t : t + waits + 1;
        resp_q.push_back(p);

        mem_en = 1'b1; Load = ld; Store = st; fun3 = f3;
        alu_result = a; store_data = sd; dmem_ack = 1'b0;
        @(posedge clk); #1;
        garble();
        if (!mis) begin
            repeat (waits) begin
                @(posedge clk); #1;
                garble();
            end
            dmem_ack = 1'b1; dmem_rdata = rd;
            @(posedge clk); #1;
            garble();
            dmem_ack = 1'($urandom); dmem_rdata = $urandom;
        end
        @(posedge clk); #1;
        mem_en = 1'b0; Load = 1'($urandom); Store = 1'($urandom);
        dmem_ack = 1'($urandom);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            dmem_ack = 1'($urandom); Load = 1'($urandom);
        end
        dmem_ack = 1'b0;
    endtask

    // Monitor: compares every presented request and completion with the scoreboard
    initial begin : monitor
        req_t  r;
        resp_t p;
        int    req_cycles;
        req_cycles = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_cycles = 0;
            end else begin
                if (dmem_req) begin
                    if (req_q.size() == 0) begin
                        chk("unexpected_req", 32'(dmem_req), 32'h0);
                    end else begin
                        r = req_q[0];
                        chk("req_addr", dmem_addr, r.addr);
                        chk("req_we", 32'(dmem_we), 32'(r.we));
                        chk("req_wmask", 32'(dmem_wmask), 32'(r.mask));
                        if (r.we) chk("req_wdata", dmem_wdata, r.wdata);
                        req_cycles++;
                        if (dmem_ack) begin
                            chk("req_cycles", 32'(req_cycles), 32'(r.cycles));
                            void'(req_q.pop_front());
                            req_cycles = 0;
                        end
                    end
                end
                if (DM_valid) begin
                    if (resp_q.size() == 0) begin
                        chk("unexpected_dm_valid", 32'(DM_valid), 32'h0);
                    end else begin
                        p = resp_q.pop_front();
                        chk("misalign_err", 32'(misalign_err), 32'(p.mis));
                        chk("load_data", rwd_data_out, p.ld);
                        chk("dm_valid_cycle", 32'(cyc), 32'(p.cyc));
                    end
                end else if (misalign_err) begin
                    chk("misalign_without_valid", 32'(misalign_err), 32'h0);
                end
            end
        end
    end

    initial begin : stimulus
        logic [2:0] lf3 [5];
        logic [2:0] f3;
        logic       ld;
        logic       st;
        lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst = 1'b1; mem_en = 1'b0; Load = 1'b0; Store = 1'b0; fun3 = 3'b000;
        mem_to_reg = 2'b01; alu_result = 32'h0; store_data = 32'h0;
        pc_plus4 = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_we", 32'(dmem_we), 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_wmask", 32'(dmem_wmask), 32'h0);
        chk("rst_dm_valid", 32'(DM_valid), 32'h0);
        chk("rst_misalign", 32'(misalign_err), 32'h0);
        chk("rst_load_reg", rwd_data_out, 32'h0);
        mem_to_reg = 2'b00; alu_result = 32'h1234_5678; #1;
        chk("wb_alu", rwd_data_out, 32'h1234_5678);
        mem_to_reg = 2'b11; #1;
        chk("wb_zero", rwd_data_out, 32'h0);
        mem_to_reg = 2'b10; pc_plus4 = 32'hCAFE_0004; #1;
        chk("wb_pc4", rwd_data_out, 32'hCAFE_0004);
        mem_to_reg = 2'b01;
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases
        do_txn(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
        do_txn(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_1234, 3);
        do_txn(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_1234, 2);
        do_txn(1'b0, 1'b1, 3'b001, 32'h42, 32'h0000_ABCD, 32'h0, 1);
        do_txn(1'b1, 1'b0, 3'b101, 32'h42, 32'h0, 32'hABCD_0000, 0);
        do_txn(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h5555_5555, 0);
        do_txn(1'b1, 1'b1, 3'b001, 32'h512, 32'h1111_2222, 32'h8765_4321, 1);

        // Reset while a request is outstanding, then a stale ack
        begin
            req_t r;
            r.addr = 32'h300; r.we = 1'b0; r.mask = 4'b0000; r.wdata = 32'h0; r.cycles = 0;
            req_q.push_back(r);
            mem_en = 1'b1; Load = 1'b1; Store = 1'b0; fun3 = 3'b010; alu_result = 32'h300;
            @(posedge clk); #1;
            mem_en = 1'b0; Load = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            void'(req_q.pop_front());
            chk("midrst_req", 32'(dmem_req), 32'h0);
            chk("midrst_dm_valid", 32'(DM_valid), 32'h0);
            chk("midrst_load_reg", rwd_data_out, 32'h0);
            model_ld = 32'h0;
            rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            mem_to_reg = 2'b10; pc_plus4 = 32'h24; #1;
            chk("midrst_wb_pc4", rwd_data_out, 32'h24);
            mem_to_reg = 2'b01;
        end

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            ld = 1'($urandom);
            st = !ld || ($urandom_range(0, 7) == 0);
            f3 = ld ? lf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            do_txn(ld, st, f3, ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3)),
                   $urandom, $urandom, $urandom_range(0, 4));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("req_queue_drained", 32'(req_q.size()), 32'h0);
        chk("resp_queue_drained", 32'(resp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
